data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory request/acknowledge interface.
- Sits behind the memory pipeline stage and services one word-aligned load or store at a time from an internal word-addressed RAM.
- Programmable wait-state latency.
- Returns a one-cycle acknowledge, plus read data for loads.

---
 rtl/data_mem_responder_if.sv | 51 +++++
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//
// Purpose : CPU data-memory request/acknowledge bundle between the memory
//           pipeline stage (master) and the data-memory responder (slave).
//
// Signals : i_mem_req     request valid, held by the master until ack
//           i_mem_addr    byte address, bits [1:0] ignored by the responder
//           i_mem_data    store data
//           i_read_write  0 = load, 1 = store
//           o_mem_ack     one-cycle acknowledge
//           o_mem_data    load data, valid while o_mem_ack = 1
//           o_busy        responder is not idle
//           o_mem_err     out-of-range access flag (DMEM_RANGE_ERR_EN only)
//
// Macro   : DMEM_RANGE_ERR_EN adds o_mem_err.
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
   parameter int XLEN = 32
);
   logic            i_mem_req;
   logic [XLEN-1:0] i_mem_addr;
   logic [XLEN-1:0] i_mem_data;
   logic            i_read_write;
   logic            o_mem_ack;
   logic [XLEN-1:0] o_mem_data;
   logic            o_busy;
`ifdef DMEM_RANGE_ERR_EN
   logic            o_mem_err;

   modport master (
      output i_mem_req, i_mem_addr, i_mem_data, i_read_write,
      input  o_mem_ack, o_mem_data, o_busy, o_mem_err
   );

   modport slave (
      input  i_mem_req, i_mem_addr, i_mem_data, i_read_write,
      output o_mem_ack, o_mem_data, o_busy, o_mem_err
   );
`else
   modport master (
      output i_mem_req, i_mem_addr, i_mem_data, i_read_write,
      input  o_mem_ack, o_mem_data, o_busy
   );

   modport slave (
      input  i_mem_req, i_mem_addr, i_mem_data, i_read_write,
      output o_mem_ack, o_mem_data, o_busy
   );
`endif
endinterface : data_mem_responder_if

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose : Responder end of the CPU data-memory interface. Services one
//           word-aligned load or store at a time from an internal
//           word-addressed RAM after LATENCY wait cycles, then returns a
//           one-cycle acknowledge (plus read data for loads).
//
// Ports   : i_clk   CPU clock, rising edge
//           i_rst   asynchronous active-high reset
//           bus     data_mem_responder_if.slave (request/ack bundle)
//
// Params  : XLEN         data/address width
//           DEPTH_WORDS  RAM depth in words, power of two
//           LATENCY      wait cycles between capture and ack, 0..15
//
// Macro   : DMEM_RANGE_ERR_EN -- addresses at or above 4*DEPTH_WORDS are
//           flagged on o_mem_err with the ack; their stores are dropped and
//           their loads return 0. Without it the index wraps modulo
//           DEPTH_WORDS.
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic                  i_clk,
   input logic                  i_rst,
   data_mem_responder_if.slave  bus
);

   localparam int         AW  = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_RELEASE
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            capture;

   // Latched request
   logic [AW-1:0]   idx_q;
   logic [XLEN-1:0] data_q;
   logic            rw_q;
   logic            oob_q;

   // Request as seen by the array access: live inputs when the access
   // happens on the capture edge itself (LATENCY = 0), latched otherwise.
   logic [AW-1:0]   in_idx, acc_idx;
   logic            in_oob, acc_oob;
   logic [XLEN-1:0] acc_data;
   logic            acc_rw;
   logic            enter_ack;

   logic [XLEN-1:0] mem [DEPTH_WORDS];
   logic [XLEN-1:0] rdata_q;

   assign in_idx = bus.i_mem_addr[AW+1:2];

`ifdef DMEM_RANGE_ERR_EN
   assign in_oob = |bus.i_mem_addr[XLEN-1:AW+2];

   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.i_mem_addr[1:0];
`else
   assign in_oob = 1'b0;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_mem_addr[XLEN-1:AW+2], bus.i_mem_addr[1:0]};
`endif

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path through the case statement can leave it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_mem_req) begin
               capture = 1'b1;
               cnt_d   = LAT;
               state_d = (LAT == 4'd0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            // A request still held after ack is not a new request.
            if (!bus.i_mem_req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      enter_ack = (state_d == ST_ACK);

      if (state_q == ST_IDLE) begin
         acc_idx  = in_idx;
         acc_oob  = in_oob;
         acc_data = bus.i_mem_data;
         acc_rw   = bus.i_read_write;
      end else begin
         acc_idx  = idx_q;
         acc_oob  = oob_q;
         acc_data = data_q;
         acc_rw   = rw_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         rw_q    <= 1'b0;
         oob_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            idx_q  <= in_idx;
            data_q <= bus.i_mem_data;
            rw_q   <= bus.i_read_write;
            oob_q  <= in_oob;
         end
         // Stores leave the read data register untouched.
         if (enter_ack && !acc_rw) begin
            rdata_q <= acc_oob ? '0 : mem[acc_idx];
         end
      end
   end

   // NOTE: the RAM array has no reset; contents survive i_rst. The write is
   // still qualified by i_rst so a reset on the ack-entry edge drops it.
   always_ff @(posedge i_clk) begin
      if (enter_ack && acc_rw && !acc_oob && !i_rst) begin
         mem[acc_idx] <= acc_data;
      end
   end

   assign bus.o_mem_ack  = (state_q == ST_ACK);
   assign bus.o_busy     = (state_q != ST_IDLE);
   assign bus.o_mem_data = rdata_q;
`ifdef DMEM_RANGE_ERR_EN
   assign bus.o_mem_err  = (state_q == ST_ACK) && oob_q;
`endif

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed and randomized loads/stores against data_mem_responder. The
// reference model is a word array indexed by (addr / 4) mod DEPTH plus the
// expected latency, ack and busy behaviour of a single transaction.
// Honours DMEM_RANGE_ERR_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam int XLEN    = 32;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   data_mem_responder_if #(.XLEN(XLEN)) bus ();

   data_mem_responder #(
      .XLEN        (XLEN),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LATENCY)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [int];
   logic [31:0] exp_rdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] addr);
      return int'((addr >> 2) % DEPTH);
   endfunction

   function automatic bit out_of_range(input logic [31:0] addr);
`ifdef DMEM_RANGE_ERR_EN
      return addr >= 32'(4 * DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   // One complete transaction, entered and left on a falling edge.
   // scramble: disturb addr/data/rw while waiting; hold: extra cycles req
   // stays high after the ack.
   task automatic do_op(input logic [31:0] addr, input logic [31:0] data,
                        input logic rw, input bit scramble, input int hold);
      int n;
      bit got;
      bit oob;
      bit known;
      oob   = out_of_range(addr);
      known = 1'b1;

      bus.i_mem_req    = 1'b1;
      bus.i_mem_addr   = addr;
      bus.i_mem_data   = data;
      bus.i_read_write = rw;
      @(posedge clk);

      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.o_mem_ack) begin
            got = 1'b1;
         end else begin
            check("busy_wait", 64'(bus.o_busy), 64'd1);
            if (scramble) begin
               bus.i_mem_addr   = $urandom;
               bus.i_mem_data   = 32'hFFFF_FFFF;
               bus.i_read_write = 1'($urandom);
            end
         end
      end
      check("ack_latency", 64'(n), 64'(LATENCY + 1));

      // Reference effect of the access
      if (rw) begin
         if (!oob) ref_mem[word_of(addr)] = data;
      end else if (oob) begin
         exp_rdata = '0;
      end else if (ref_mem.exists(word_of(addr))) begin
         exp_rdata = ref_mem[word_of(addr)];
      end else begin
         known = 1'b0;
      end

      if (known) check("ack_data", 64'(bus.o_mem_data), 64'(exp_rdata));
      check("busy_ack", 64'(bus.o_busy), 64'd1);
`ifdef DMEM_RANGE_ERR_EN
      check("err_ack", 64'(bus.o_mem_err), 64'(oob));
`endif

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_no_ack", 64'(bus.o_mem_ack), 64'd0);
         check("hold_busy", 64'(bus.o_busy), 64'd1);
      end

      bus.i_mem_req = 1'b0;
      if (hold == 0) begin
         @(negedge clk);
         check("release_no_ack", 64'(bus.o_mem_ack), 64'd0);
         check("release_busy", 64'(bus.o_busy), 64'd1);
      end
      @(negedge clk);
      check("idle_busy", 64'(bus.o_busy), 64'd0);
      check("idle_no_ack", 64'(bus.o_mem_ack), 64'd0);
      if (known) check("rdata_held", 64'(bus.o_mem_data), 64'(exp_rdata));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;

      rst              = 1'b1;
      bus.i_mem_req    = 1'b0;
      bus.i_mem_addr   = '0;
      bus.i_mem_data   = '0;
      bus.i_read_write = 1'b0;
      exp_rdata        = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ack", 64'(bus.o_mem_ack), 64'd0);
      check("rst_busy", 64'(bus.o_busy), 64'd0);
      check("rst_data", 64'(bus.o_mem_data), 64'd0);
`ifdef DMEM_RANGE_ERR_EN
      check("rst_err", 64'(bus.o_mem_err), 64'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Store then load with ignored low address bits, data held afterwards
      do_op(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
      do_op(32'h0000_0013, 32'h0, 1'b0, 1'b0, 0);
      check("load_low_bits", 64'(exp_rdata), 64'h0000_0000_DEAD_BEEF);
      repeat (5) @(negedge clk);
      check("data_hold_5", 64'(bus.o_mem_data), 64'h0000_0000_DEAD_BEEF);

      // Request held high for 10 cycles after ack: single service
      do_op(32'h0000_0020, 32'h0BAD_F00D, 1'b1, 1'b0, 0);
      do_op(32'h0000_0020, 32'h0, 1'b0, 1'b0, 10);

      // Inputs disturbed during WAIT are ignored
      do_op(32'h0000_0040, 32'h1234_5678, 1'b1, 1'b1, 0);
      do_op(32'h0000_0040, 32'h0, 1'b0, 1'b0, 0);
      check("wait_ignored", 64'(bus.o_mem_data), 64'h0000_0000_1234_5678);

      // Reset one cycle after capturing a store discards it
      do_op(32'h0000_0080, 32'hA5A5_0080, 1'b1, 1'b0, 0);
      bus.i_mem_req    = 1'b1;
      bus.i_mem_addr   = 32'h0000_0080;
      bus.i_mem_data   = 32'h5A5A_FFFF;
      bus.i_read_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst           = 1'b1;
      bus.i_mem_req = 1'b0;
      #1;
      check("midrst_ack", 64'(bus.o_mem_ack), 64'd0);
      check("midrst_busy", 64'(bus.o_busy), 64'd0);
      check("midrst_data", 64'(bus.o_mem_data), 64'd0);
      exp_rdata = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("postrst_no_ack", 64'(bus.o_mem_ack), 64'd0);
      end
      do_op(32'h0000_0080, 32'h0, 1'b0, 1'b0, 0);
      check("rst_discard", 64'(bus.o_mem_data), 64'h0000_0000_A5A5_0080);

      // Address beyond the array
      do_op(32'h0000_0000, 32'hCAFE_0000, 1'b1, 1'b0, 0);
      do_op(32'h0000_1000, 32'h0, 1'b0, 1'b0, 0);
`ifdef DMEM_RANGE_ERR_EN
      check("range_data", 64'(bus.o_mem_data), 64'd0);
`else
      check("wrap_data", 64'(bus.o_mem_data), 64'h0000_0000_CAFE_0000);
`endif

      // Randomized traffic over words 0..15, some with high address bits
      for (int w = 0; w < 16; w++) begin
         do_op(32'(w * 4), $urandom, 1'b1, 1'b0, 0);
      end
      for (int k = 0; k < 40; k++) begin
         a = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
         if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
         do_op(a, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_data_mem_responder
